// File: rtl/io_bridge.sv
// io_bridge: responder for the 32-bit host streaming interface, exposed to
// the CPU as an 8-bit register bus.
//   addr 0-3 : write DOUT shadow bytes / read captured input word bytes
//   addr 4   : write CTRL {SEND, REQ} / read STATUS
//   addr 5-7 : read as zero, writes ignored
// The input path is a three-state request FSM with an optional timeout.
// The output path fires the shadow word for a fixed number of cycles.
module io_bridge #(
  parameter int unsigned DOUT_RDY_CYCLES = 1,  // legal range 1..255
  parameter int unsigned REQ_TIMEOUT     = 0   // 0 disables the timeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we_n,
  input  logic [2:0]  addr,
  input  logic [7:0]  datai,
  output logic [7:0]  datao,
  input  logic [31:0] din,
  input  logic        din_rdy,
  output logic        din_req,
  output logic [31:0] dout,
  output logic        dout_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } in_state_t;

  localparam logic [7:0]  HOLD_INIT  = 8'(DOUT_RDY_CYCLES);
  localparam logic        TIMEOUT_EN = (REQ_TIMEOUT != 0);
  // Counter value seen on the edge where the timeout expires.
  localparam logic [15:0] TO_LAST    = (REQ_TIMEOUT == 0) ? 16'd0 : 16'(REQ_TIMEOUT - 1);

  in_state_t   state;
  logic [31:0] din_reg;
  logic [31:0] shadow;
  logic [15:0] to_cnt;
  logic [7:0]  hold_cnt;
  logic        err_req;
  logic        err_to;
  logic        err_send;

  // CPU access decode
  logic       rd_acc;
  logic       wr_acc;
  logic       ctrl_wr;
  logic       req_cmd;
  logic       send_cmd;
  logic       status_rd;
  logic       last_byte_rd;
  logic       timeout_fire;
  logic [7:0] status;

  assign rd_acc       = cs & we_n;
  assign wr_acc       = cs & ~we_n;
  assign ctrl_wr      = wr_acc & (addr == 3'd4);
  assign req_cmd      = ctrl_wr & datai[0];
  assign send_cmd     = ctrl_wr & datai[1];
  assign status_rd    = rd_acc & (addr == 3'd4);
  assign last_byte_rd = rd_acc & (addr == 3'd3);

  // A waiting request gives up only if the host is not delivering on this
  // very edge; a capture always beats an expiring timeout.
  assign timeout_fire = TIMEOUT_EN && (state == REQ) && !din_rdy && (to_cnt == TO_LAST);

  // BUSY is exactly the dout_rdy window, so the output flag doubles as it.
  assign status = {2'b00, err_send, dout_rdy, err_to, err_req,
                   (state == REQ), (state == FULL)};

  // Input request FSM: IDLE -> REQ on CTRL.REQ, REQ -> FULL on capture,
  // FULL -> IDLE once the CPU reads the top byte.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state uses non-blocking assignments so every block samples
    // the pre-edge values, which is what makes same-edge events resolve cleanly.
    if (!rst_n) begin
      state   <= IDLE;
      din_req <= 1'b0;
      din_reg <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_cmd) begin
            state   <= REQ;
            din_req <= 1'b1;
            to_cnt  <= '0;
          end
        end
        REQ: begin
          if (din_rdy) begin
            din_reg <= din;
            din_req <= 1'b0;
            state   <= FULL;
          end else if (timeout_fire) begin
            din_req <= 1'b0;
            state   <= IDLE;
          end else if (TIMEOUT_EN) begin
            to_cnt  <= to_cnt + 16'd1;
          end
        end
        FULL: begin
          if (last_byte_rd) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          din_req <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags: set by the offending event, cleared by a STATUS
  // read; a set on the same edge as the read survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_req  <= 1'b0;
      err_to   <= 1'b0;
      err_send <= 1'b0;
    end else begin
      if (req_cmd && (state != IDLE)) err_req <= 1'b1;
      else if (status_rd)             err_req <= 1'b0;

      if (timeout_fire)               err_to <= 1'b1;
      else if (status_rd)             err_to <= 1'b0;

      if (send_cmd && dout_rdy)       err_send <= 1'b1;
      else if (status_rd)             err_send <= 1'b0;
    end
  end

  // Output shadow: CPU stages the next word bytewise, little-endian.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow is a plain 32-bit register, not a memory, so it is
    // cheap to reset and its cleared value is architecturally visible.
    if (!rst_n) begin
      shadow <= '0;
    end else if (wr_acc && !addr[2]) begin
      shadow[8*addr[1:0] +: 8] <= datai;
    end
  end

  // Output sender: copy the shadow and hold dout_rdy for DOUT_RDY_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_rdy <= 1'b0;
      hold_cnt <= '0;
    end else if (dout_rdy) begin
      if (hold_cnt == 8'd1) begin
        dout_rdy <= 1'b0;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end else if (send_cmd) begin
      dout     <= shadow;
      dout_rdy <= 1'b1;
      hold_cnt <= HOLD_INIT;
    end
  end

  // Read data mux for the CPU bus.
  logic [7:0] rd_data;
  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = 8'h00;
    case (addr)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = din_reg[8*addr[1:0] +: 8];
      3'd4:                   rd_data = status;
      default:                rd_data = 8'h00;
    endcase
  end

  // Registered read data: updates on the read edge and holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datao <= 8'h00;
    end else if (rd_acc) begin
      datao <= rd_data;
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: two io_bridge instances share one stimulus stream.
//   dut_a : DOUT_RDY_CYCLES=1, REQ_TIMEOUT=0
//   dut_b : DOUT_RDY_CYCLES=4, REQ_TIMEOUT=8
// A transaction-level reference model tracks each instance; directed
// scenarios check fixed expected values, then a random phase compares the
// outputs against the model every cycle.
module tb_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs, we_n;
  logic [2:0]  addr;
  logic [7:0]  datai;
  logic [31:0] din;
  logic        din_rdy;

  logic [7:0]  datao_a, datao_b;
  logic        din_req_a, din_req_b;
  logic [31:0] dout_a, dout_b;
  logic        dout_rdy_a, dout_rdy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_bridge #(.DOUT_RDY_CYCLES(1), .REQ_TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_n(we_n), .addr(addr), .datai(datai),
    .datao(datao_a), .din(din), .din_rdy(din_rdy), .din_req(din_req_a),
    .dout(dout_a), .dout_rdy(dout_rdy_a)
  );

  io_bridge #(.DOUT_RDY_CYCLES(4), .REQ_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we_n(we_n), .addr(addr), .datai(datai),
    .datao(datao_b), .din(din), .din_rdy(din_rdy), .din_req(din_req_b),
    .dout(dout_b), .dout_rdy(dout_rdy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: per instance, a pending/valid flag pair, sticky error
  // bits, remaining cycles of the dout_rdy window and cycles spent waiting.
  // ---------------------------------------------------------------------
  bit          m_pend[2], m_valid[2];
  bit          m_err_req[2], m_err_to[2], m_err_send[2];
  int          m_busy[2], m_wait[2];
  logic [31:0] m_din_reg[2], m_shadow[2], m_dout[2];
  logic [7:0]  m_datao[2];

  function automatic int hold_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int timeout_of(int i);
    return (i == 0) ? 0 : 8;
  endfunction

  function automatic logic [7:0] m_status(int i);
    return {2'b00, m_err_send[i], (m_busy[i] > 0), m_err_to[i], m_err_req[i],
            m_pend[i], m_valid[i]};
  endfunction

  function automatic void m_reset(int i);
    m_pend[i] = 0; m_valid[i] = 0;
    m_err_req[i] = 0; m_err_to[i] = 0; m_err_send[i] = 0;
    m_busy[i] = 0; m_wait[i] = 0;
    m_din_reg[i] = '0; m_shadow[i] = '0; m_dout[i] = '0; m_datao[i] = '0;
  endfunction

  function automatic void m_step(int i);
    bit rd = cs && we_n;
    bit wr = cs && !we_n;
    bit old_pend = m_pend[i];
    bit old_valid = m_valid[i];
    int old_busy = m_busy[i];
    logic [7:0] st = m_status(i);
    int sel = int'(addr);

    if (rd) m_datao[i] = (sel < 4) ? m_din_reg[i][8*sel +: 8] : (sel == 4) ? st : 8'h00;
    if (rd && sel == 4) begin
      m_err_req[i] = 0; m_err_to[i] = 0; m_err_send[i] = 0;
    end

    // input side
    if (old_pend) begin
      if (din_rdy) begin
        m_din_reg[i] = din; m_pend[i] = 0; m_valid[i] = 1;
      end else begin
        m_wait[i]++;
        if (timeout_of(i) > 0 && m_wait[i] == timeout_of(i)) begin
          m_pend[i] = 0; m_err_to[i] = 1;
        end
      end
    end else if (old_valid && rd && sel == 3) begin
      m_valid[i] = 0;
    end
    if (wr && sel == 4 && datai[0]) begin
      if (old_pend || old_valid) m_err_req[i] = 1;
      else begin
        m_pend[i] = 1; m_wait[i] = 0;
      end
    end

    // output side
    if (old_busy > 0) m_busy[i]--;
    if (wr && sel == 4 && datai[1]) begin
      if (old_busy > 0) m_err_send[i] = 1;
      else begin
        m_dout[i] = m_shadow[i]; m_busy[i] = hold_of(i);
      end
    end
    if (wr && sel < 4) m_shadow[i][8*sel +: 8] = datai;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m_reset(i);
    end else begin
      for (int i = 0; i < 2; i++) m_step(i);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("a_din_req",  din_req_a,  m_pend[0]);
    check("a_dout_rdy", dout_rdy_a, m_busy[0] > 0);
    check("a_dout",     dout_a,     m_dout[0]);
    check("a_datao",    datao_a,    m_datao[0]);
    check("b_din_req",  din_req_b,  m_pend[1]);
    check("b_dout_rdy", dout_rdy_b, m_busy[1] > 0);
    check("b_dout",     dout_b,     m_dout[1]);
    check("b_datao",    datao_b,    m_datao[1]);
  end

  // Pulse-length monitors (length of the most recently completed pulse).
  int run_a = 0, last_a = 0, run_b = 0, last_b = 0, run_rq = 0, last_rq = 0;
  always @(negedge clk) begin
    if (dout_rdy_a) run_a++;
    else if (run_a > 0) begin last_a = run_a; run_a = 0; end
    if (dout_rdy_b) run_b++;
    else if (run_b > 0) begin last_b = run_b; run_b = 0; end
    if (din_req_b) run_rq++;
    else if (run_rq > 0) begin last_rq = run_rq; run_rq = 0; end
  end

  // CPU bus tasks: called at a falling edge, return one falling edge later.
  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we_n = 1'b0; addr = a; datai = d;
    @(negedge clk);
    cs = 1'b0; we_n = 1'b1;
  endtask

  task automatic cpu_rd(input logic [2:0] a);
    cs = 1'b1; we_n = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] b2b_word;
  logic [7:0]  exp_bytes[4];

  initial begin
    cs = 1'b0; we_n = 1'b1; addr = '0; datai = '0; din = '0; din_rdy = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check("rst_din_req_a", din_req_a, 1'b0);
    check("rst_dout_b", dout_b, 32'h0);
    rst_n = 1'b1;
    idle(1);
    cpu_rd(3'd4);
    check("rst_status_a", datao_a, 8'h00);
    check("rst_status_b", datao_b, 8'h00);

    // Output path
    cpu_wr(3'd0, 8'h2A); cpu_wr(3'd1, 8'h00); cpu_wr(3'd2, 8'h00); cpu_wr(3'd3, 8'h00);
    cpu_wr(3'd4, 8'h02);
    check("send_rdy_a", dout_rdy_a, 1'b1);
    check("send_dout_a", dout_a, 32'h0000_002A);
    check("send_dout_b", dout_b, 32'h0000_002A);
    idle(1);
    check("send_rdy_a_drop", dout_rdy_a, 1'b0);
    check("send_dout_a_hold", dout_a, 32'h0000_002A);
    check("send_rdy_b_still", dout_rdy_b, 1'b1);
    idle(5);
    check("pulse_len_a", last_a, 1);
    check("pulse_len_b", last_b, 4);
    cpu_rd(3'd4);
    check("send_status_a", datao_a, 8'h00);
    check("send_status_b", datao_b, 8'h00);

    // Input path
    din = 32'h3F80_0000;
    cpu_wr(3'd4, 8'h01);
    check("req_rise_a", din_req_a, 1'b1);
    check("req_rise_b", din_req_b, 1'b1);
    din_rdy = 1'b1;
    idle(1);
    check("req_fall_a", din_req_a, 1'b0);
    check("req_fall_b", din_req_b, 1'b0);
    din_rdy = 1'b0;
    cpu_rd(3'd4);
    check("full_status_a", datao_a, 8'h01);
    exp_bytes = '{8'h00, 8'h00, 8'h80, 8'h3F};
    for (int k = 0; k < 4; k++) begin
      cpu_rd(3'(k));
      check($sformatf("din_byte%0d_a", k), datao_a, exp_bytes[k]);
      check($sformatf("din_byte%0d_b", k), datao_b, exp_bytes[k]);
    end
    cpu_rd(3'd4);
    check("empty_status_a", datao_a, 8'h00);
    check("empty_status_b", datao_b, 8'h00);

    // Back-to-back request with din_rdy already high
    b2b_word = $urandom;
    din = b2b_word; din_rdy = 1'b1;
    cpu_wr(3'd4, 8'h01);
    check("b2b_req_a", din_req_a, 1'b1);
    idle(1);
    check("b2b_req_drop_a", din_req_a, 1'b0);
    check("b2b_req_drop_b", din_req_b, 1'b0);
    din_rdy = 1'b0;

    // Request while FULL
    cpu_wr(3'd4, 8'h01);
    cpu_rd(3'd4);
    check("err_req_status_a", datao_a, 8'h05);
    check("err_req_status_b", datao_b, 8'h05);
    cpu_rd(3'd4);
    check("err_req_clear_b", datao_b, 8'h01);
    cpu_rd(3'd3);
    check("b2b_top_byte_b", datao_b, {24'h0, b2b_word[31:24]});
    cpu_rd(3'd4);
    check("b2b_empty_a", datao_a, 8'h00);

    // Send while busy
    cpu_wr(3'd4, 8'h02);
    cpu_wr(3'd4, 8'h02);
    cpu_rd(3'd4);
    check("err_send_status_a", datao_a, 8'h20);
    check("err_send_status_b", datao_b, 8'h30);
    idle(6);
    check("err_send_pulse_b", last_b, 4);
    cpu_rd(3'd4);
    check("err_send_clear_b", datao_b, 8'h00);

    // Timeout (instance b only; instance a keeps waiting)
    din_rdy = 1'b0;
    cpu_wr(3'd4, 8'h01);
    idle(12);
    check("to_req_low_b", din_req_b, 1'b0);
    check("to_req_len_b", last_rq, 8);
    check("to_req_high_a", din_req_a, 1'b1);
    cpu_rd(3'd4);
    check("to_status_b", datao_b, 8'h08);
    check("to_status_a", datao_a, 8'h02);
    cpu_rd(3'd3);
    check("to_din_reg_kept_b", datao_b, {24'h0, b2b_word[31:24]});
    din = $urandom; din_rdy = 1'b1;
    idle(1);
    din_rdy = 1'b0;
    cpu_rd(3'd3);
    check("a_capture_byte3", datao_a, {24'h0, din[31:24]});
    cpu_rd(3'd4);
    check("to_status_clear_b", datao_b, 8'h00);
    check("a_idle_again", datao_a, 8'h00);

    // Reset in the middle of a request and a send
    cpu_wr(3'd4, 8'h01);
    cpu_wr(3'd4, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_din_req_b", din_req_b, 1'b0);
    check("mid_rst_dout_rdy_b", dout_rdy_b, 1'b0);
    check("mid_rst_dout_a", dout_a, 32'h0);
    check("mid_rst_dout_rdy_a", dout_rdy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    cpu_rd(3'd4);
    check("post_rst_status_a", datao_a, 8'h00);
    check("post_rst_status_b", datao_b, 8'h00);

    // Random phase: model comparison runs every cycle
    for (int n = 0; n < 3000; n++) begin
      cs      = ($urandom_range(0, 99) < 50);
      we_n    = $urandom_range(0, 1) == 1;
      addr    = ($urandom_range(0, 99) < 35) ? 3'd4 : 3'($urandom_range(0, 7));
      datai   = (addr == 3'd4) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      din     = $urandom;
      din_rdy = ($urandom_range(0, 99) < 20);
      @(negedge clk);
    end
    cs = 1'b0; din_rdy = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Platform-side responder for the 32-bit streaming IO interface (din/din_rdy/din_req, dout/dout_rdy) driven by the external bench or host.
- Bridges that interface to the 8-bit CPU register bus inside top_level.
- The CPU requests input words, reads them bytewise, stages output words bytewise and fires them to the host.
- Contains independent input and output paths with a request timeout.

Parameters:
- DOUT_RDY_CYCLES, 1: cycles dout_rdy stays high per send; legal range 1..255.
- REQ_TIMEOUT, 0: max cycles to wait for din_rdy after din_req rises; 0 disables timeout; 16-bit counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  CPU access strobe; high exactly one cycle per access.
- we_n  in  1  CPU write enable, active-low; cs&!we_n = write, cs&we_n = read.
- addr  in  3  register index.
- datai  in  8  CPU write data.
- datao  out  8  CPU read data, registered.
- din  in  32  host input word.
- din_rdy  in  1  host input-valid level.
- din_req  out  1  input word requested.
- dout  out  32  output word to host.
- dout_rdy  out  1  output word valid.

Behaviour:
- Reset (async, rst_n=0): datao=0, din_req=0, dout=0, dout_rdy=0, shadow=0, din_reg=0, all status bits 0, FSM=IDLE, counters 0.
- Register map, little-endian:
  - addr 0-3 write: DOUT shadow bytes 0..3. Read: din_reg bytes 0..3.
  - addr 4 write CTRL: bit0 REQ, bit1 SEND; other bits ignored.
  - addr 4 read STATUS: bit0 VALID, bit1 PENDING, bit2 ERR_REQ, bit3 ERR_TO, bit4 BUSY, bit5 ERR_SEND, bits7:6 = 0.
  - addr 5-7: reads return 0; writes ignored.
- Read latency: datao updates on the edge where cs&we_n is sampled and holds until the next read.
- A STATUS read returns the pre-clear value. ERR_REQ, ERR_TO and ERR_SEND clear on that same edge.
- Input FSM, states IDLE / REQ / FULL:
  - IDLE: CTRL.REQ write -> REQ; din_req=1 from the next cycle; timeout counter=0.
  - REQ: if din_rdy=1 on an edge, capture din into din_reg, set din_req=0, go FULL (VALID=1). din_rdy is a level; no edge detection. A level already high at entry captures on the first REQ edge.
  - REQ with REQ_TIMEOUT>0: counter increments each cycle. On reaching REQ_TIMEOUT without din_rdy: din_req=0, ERR_TO=1, -> IDLE, din_reg unchanged.
  - FULL: a CPU read of addr 3 -> IDLE (VALID=0). Reads of bytes 0-2 have no side effect.
  - REQ write while in REQ or FULL: ignored, ERR_REQ=1.
  - PENDING equals (state==REQ).
- Output path:
  - CTRL.SEND with BUSY=0: on the next edge, dout<=shadow, dout_rdy=1, BUSY=1, hold counter loaded.
  - dout_rdy stays high exactly DOUT_RDY_CYCLES cycles, then 0 and BUSY=0. dout holds its value after dout_rdy falls.
  - SEND while BUSY=1: ignored, ERR_SEND=1.
  - Shadow writes during BUSY are allowed and do not affect the dout in flight.
- Simultaneous events:
  - CTRL write with REQ=1 and SEND=1 in one access: both actions are evaluated independently.
  - din_rdy capture and a STATUS read on the same edge: datao shows the pre-capture status (VALID=0); VALID is 1 afterwards.
  - Timeout expiring on the same edge din_rdy=1: capture wins, ERR_TO not set.
- Reset mid-operation: all state returns to reset values immediately, including dout_rdy dropping asynchronously, and any din_req in progress is dropped.

Test Plan:
- Reset: hold rst_n=0 mid-REQ with dout_rdy high -> din_req=0, dout_rdy=0, dout=0 immediately; STATUS read after release = 0x00.
- Output: write 0x2A,0x00,0x00,0x00 to addr 0-3, then CTRL=0x02 -> dout=0x0000002A, dout_rdy high exactly 1 cycle (DOUT_RDY_CYCLES=1); STATUS bit4 reads 0 afterwards.
- Input:
  - Write CTRL=0x01 -> din_req=1 next cycle.
  - Host sets din=0x3F800000 and holds din_rdy=1 -> din_req=0 after one edge; STATUS=0x01.
  - Reads of addr 0..3 return 0x00,0x00,0x80,0x3F; STATUS then reads 0x00.
- Back-to-back input with din_rdy held high: second CTRL=0x01 -> capture on the first REQ edge; din_req high for exactly 1 cycle.
- Errors:
  - CTRL=0x01 while FULL -> STATUS=0x05, next STATUS read=0x01.
  - Two CTRL=0x02 writes 1 cycle apart with DOUT_RDY_CYCLES=4 -> single 4-cycle dout_rdy pulse; STATUS shows bit5=1 (0x30 if read while still BUSY).
- Timeout: REQ_TIMEOUT=8, CTRL=0x01, din_rdy held 0 -> din_req high 8 cycles then 0; STATUS=0x08; din_reg unchanged.
